// File: rtl/control_burst_manager.sv
// control_burst_manager: SPI-keyed command channel bridging one locked SPI
// slave channel onto an APB2 master for byte-wide burst reads and writes.
module control_burst_manager #(
    parameter int SPI_COUNT   = 8,
    parameter int INDEX_WIDTH = 8,
    parameter int ADDR_BYTES  = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SPI_COUNT-1:0]    sclks,
    input  logic [SPI_COUNT-1:0]    sins,
    output logic                    sout,
    output logic [INDEX_WIDTH-1:0]  sout_index,
    output logic                    sout_enable,
    output logic [ADDR_BYTES*8-1:0] PADDR,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [7:0]              PWDATA,
    input  logic [7:0]              PRDATA
);
    localparam int AW   = ADDR_BYTES * 8;
    localparam int CH_W = (SPI_COUNT > 1) ? $clog2(SPI_COUNT) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR_INDEX, S_HDR_COUNT, S_HDR_ADDR, S_HDR_CMD, S_DATA} state_t;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_t;

    // Unlock key, one byte per matcher stage.
    function automatic logic [7:0] key_byte(input logic [2:0] stage);
        case (stage)
            3'd0:    return 8'h92;
            3'd1:    return 8'h9d;
            3'd2:    return 8'h9a;
            3'd3:    return 8'h9b;
            3'd4:    return 8'h29;
            3'd5:    return 8'h35;
            3'd6:    return 8'ha2;
            default: return 8'h65;
        endcase
    endfunction

    logic [SPI_COUNT-1:0] sclk_meta_q, sclk_sync_q, sclk_prev_q, sin_meta_q, sin_sync_q;
    logic [SPI_COUNT-1:0] sclk_rise, sclk_fall, byte_done, key_done;
    logic [SPI_COUNT-1:0][7:0] rx_byte;
    logic frame_clr, match_clr, lock_now, expire, any_edge, apb_start, apb_wr;
    logic l_done, l_fall, l_edge;
    logic [7:0] l_byte;
    logic [CH_W-1:0] win_ch;

    state_t state_q, state_d;
    apb_t apb_q, apb_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [7:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d, paddr_q, paddr_d;
    logic [1:0] addr_byte_q, addr_byte_d;
    logic is_write_q, is_write_d, auto_inc_q, auto_inc_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic sout_en_q, sout_en_d, sout_q, sout_d;
    logic [7:0] tx_shift_q, tx_shift_d, pwdata_q, pwdata_d;
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;

    // Two-flop synchronisers for every SPI pin, plus a delayed sclk copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_meta_q <= '0; sclk_sync_q <= '0; sclk_prev_q <= '0;
            sin_meta_q  <= '0; sin_sync_q  <= '0;
        end else begin
            sclk_meta_q <= sclks;       sclk_sync_q <= sclk_meta_q; sclk_prev_q <= sclk_sync_q;
            sin_meta_q  <= sins;        sin_sync_q  <= sin_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < SPI_COUNT; gi++) begin : g_ch
            logic [2:0] bit_cnt_q, bit_cnt_d, stage_q, stage_d;
            logic [6:0] rx_shift_q, rx_shift_d;

            assign byte_done[gi] = sclk_rise[gi] && (bit_cnt_q == 3'd7);
            assign rx_byte[gi]   = {rx_shift_q, sin_sync_q[gi]};
            assign key_done[gi]  = byte_done[gi] && (stage_q == 3'd7) && (rx_byte[gi] == key_byte(3'd7));

            // Byte framing and key matching; a wrong byte that equals the first key byte restarts at stage 1.
            always_comb begin
                bit_cnt_d  = bit_cnt_q;
                rx_shift_d = rx_shift_q;
                stage_d    = stage_q;
                if (frame_clr) begin
                    bit_cnt_d = 3'd0;
                end else if (sclk_rise[gi]) begin
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    rx_shift_d = {rx_shift_q[5:0], sin_sync_q[gi]};
                end
                if (match_clr) begin
                    stage_d = 3'd0;
                end else if (byte_done[gi]) begin
                    if (rx_byte[gi] == key_byte(stage_q)) stage_d = stage_q + 3'd1;
                    else if (rx_byte[gi] == key_byte(3'd0)) stage_d = 3'd1;
                    else stage_d = 3'd0;
                end
            end

            // Per-channel framing and matcher state.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bit_cnt_q <= '0; rx_shift_q <= '0; stage_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_d; rx_shift_q <= rx_shift_d; stage_q <= stage_d;
                end
            end
        end
    endgenerate

    // Lowest-numbered channel wins when several complete the key together.
    always_comb begin
        win_ch = '0;
        for (int i = SPI_COUNT - 1; i >= 0; i--) begin
            if (key_done[i]) win_ch = CH_W'(i);
        end
    end

    assign lock_now  = (state_q == S_IDLE) && (|key_done);
    assign l_done    = byte_done[ch_q];
    assign l_fall    = sclk_fall[ch_q];
    assign l_edge    = sclk_rise[ch_q] | sclk_fall[ch_q];
    assign l_byte    = rx_byte[ch_q];
    assign any_edge  = (state_q == S_IDLE) ? (|(sclk_rise | sclk_fall)) : l_edge;
    assign expire    = !any_edge && (idle_cnt_q == TO_W'(TIMEOUT - 1));
    assign frame_clr = expire;
    // Matchers only run while unlocked, so traffic on other channels is ignored during a burst.
    assign match_clr = (state_q != S_IDLE) || lock_now || frame_clr;
    // The access launched on the command byte is always the first read.
    assign apb_wr    = (state_q == S_DATA) && is_write_q;

    // Header/data sequencing, APB master and read-data shifter; an APB access already started always finishes.
    always_comb begin
        state_d = state_q;       apb_d = apb_q;            ch_d = ch_q;
        count_d = count_q;       addr_d = addr_q;          addr_byte_d = addr_byte_q;
        is_write_d = is_write_q; auto_inc_d = auto_inc_q;  index_d = index_q;
        sout_en_d = sout_en_q;   sout_d = sout_q;          tx_shift_d = tx_shift_q;
        psel_d = psel_q;         penable_d = penable_q;    pwrite_d = pwrite_q;
        paddr_d = paddr_q;       pwdata_d = pwdata_q;      apb_start = 1'b0;
        idle_cnt_d = (any_edge || expire) ? '0 : idle_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: if (lock_now) begin
                state_d = S_HDR_INDEX;
                ch_d    = win_ch;
            end
            S_HDR_INDEX: if (l_done) begin
                index_d = INDEX_WIDTH'(l_byte);
                state_d = S_HDR_COUNT;
            end
            S_HDR_COUNT: if (l_done) begin
                count_d     = l_byte;
                addr_byte_d = 2'd0;
                state_d     = S_HDR_ADDR;
            end
            S_HDR_ADDR: if (l_done) begin
                for (int b = 0; b < ADDR_BYTES; b++) begin
                    if (addr_byte_q == 2'(b)) addr_d[b*8 +: 8] = l_byte;
                end
                addr_byte_d = addr_byte_q + 2'd1;
                if (addr_byte_q == 2'(ADDR_BYTES - 1)) state_d = S_HDR_CMD;
            end
            S_HDR_CMD: if (l_done) begin
                is_write_d = l_byte[0];
                auto_inc_d = l_byte[1];
                if (count_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    if (!l_byte[0]) begin
                        apb_start = 1'b1;
                        sout_en_d = 1'b1;
                    end
                end
            end
            S_DATA: if (l_done) begin
                count_d = count_q - 8'd1;
                if (is_write_q || (count_q != 8'd1)) apb_start = 1'b1;
                if (count_q == 8'd1) begin
                    state_d   = S_IDLE;
                    sout_en_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (expire && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            sout_en_d = 1'b0;
            apb_start = 1'b0;
        end

        // Each sclk fall presents the next read bit, MSB first.
        if (sout_en_q && l_fall) begin
            sout_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        case (apb_q)
            A_IDLE: if (apb_start) begin
                apb_d     = A_SETUP;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = addr_q;
                pwrite_d  = apb_wr;
                pwdata_d  = apb_wr ? l_byte : 8'h00;
                if (auto_inc_d) addr_d = addr_q + 1'b1;
            end
            A_SETUP: begin
                apb_d     = A_ACCESS;
                penable_d = 1'b1;
            end
            A_ACCESS: begin
                apb_d     = A_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (!pwrite_q) tx_shift_d = PRDATA;
            end
            default: apb_d = A_IDLE;
        endcase

        if (!sout_en_d) sout_d = 1'b0;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;   apb_q <= A_IDLE;      ch_q <= '0;
            count_q <= '0;       addr_q <= '0;         addr_byte_q <= '0;
            is_write_q <= 1'b0;  auto_inc_q <= 1'b0;   index_q <= '0;
            sout_en_q <= 1'b0;   sout_q <= 1'b0;       tx_shift_q <= '0;
            psel_q <= 1'b0;      penable_q <= 1'b0;    pwrite_q <= 1'b0;
            paddr_q <= '0;       pwdata_q <= '0;       idle_cnt_q <= '0;
        end else begin
            state_q <= state_d;       apb_q <= apb_d;           ch_q <= ch_d;
            count_q <= count_d;       addr_q <= addr_d;         addr_byte_q <= addr_byte_d;
            is_write_q <= is_write_d; auto_inc_q <= auto_inc_d; index_q <= index_d;
            sout_en_q <= sout_en_d;   sout_q <= sout_d;         tx_shift_q <= tx_shift_d;
            psel_q <= psel_d;         penable_q <= penable_d;   pwrite_q <= pwrite_d;
            paddr_q <= paddr_d;       pwdata_q <= pwdata_d;     idle_cnt_q <= idle_cnt_d;
        end
    end

    assign sout        = sout_q;
    assign sout_enable = sout_en_q;
    assign sout_index  = index_q;
    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
endmodule

// File: tb/tb_control_burst_manager.sv
// Bench for control_burst_manager: drives SPI bytes on chosen channels, acts as
// APB slave, and checks APB traffic and read-back bits against a burst model.
module tb_control_burst_manager;
    localparam int SC = 8;
    localparam int AB = 2;
    localparam int TO = 2000;
    localparam int H  = 6;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
    } apb_rec_t;

    logic clk = 1'b0;
    logic rst;
    logic [SC-1:0] sclks, sins;
    logic sout, sout_enable, PSEL, PENABLE, PWRITE;
    logic [7:0] sout_index, PWDATA, PRDATA;
    logic [AB*8-1:0] PADDR;

    logic [7:0] mem [65536];
    logic [7:0] model_mem [65536];
    apb_rec_t exp_q [$];
    int tests = 0;
    int fails = 0;
    logic [7:0] last_rd;

    always #5 clk = ~clk;

    control_burst_manager #(.SPI_COUNT(SC), .INDEX_WIDTH(8), .ADDR_BYTES(AB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sclks(sclks), .sins(sins), .sout(sout),
        .sout_index(sout_index), .sout_enable(sout_enable), .PADDR(PADDR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    assign PRDATA = mem[PADDR];
    always @(posedge clk) if (PSEL && PENABLE && PWRITE) mem[PADDR] <= PWDATA;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    // APB protocol/scoreboard monitor plus idle-sout check, every cycle.
    logic in_access = 1'b0;
    apb_rec_t setup_rec;
    always @(negedge clk) begin
        if (!rst) begin
            in_access = 1'b0;
        end else begin
            if (in_access) begin
                check("apb_access_phase", {PSEL, PENABLE}, 2'b11);
                check("apb_addr_stable", PADDR, setup_rec.addr);
                check("apb_write_stable", PWRITE, setup_rec.wr);
                check("apb_wdata_stable", PWDATA, setup_rec.data);
                in_access = 1'b0;
            end else if (PSEL) begin
                check("apb_setup_penable", PENABLE, 1'b0);
                setup_rec = '{PADDR, PWRITE, PWDATA};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL apb_unexpected: got access addr %0h wr %0b, required none", PADDR, PWRITE);
                end else begin
                    apb_rec_t r;
                    r = exp_q.pop_front();
                    check("apb_addr", PADDR, r.addr);
                    check("apb_pwrite", PWRITE, r.wr);
                    if (r.wr) check("apb_pwdata", PWDATA, r.data);
                end
                in_access = 1'b1;
            end else if (PENABLE) begin
                check("apb_penable_without_psel", PENABLE, 1'b0);
            end
            if (!sout_enable) check("sout_zero_when_disabled", sout, 1'b0);
        end
    end

    // Send nbits of byte b (MSB first) on every channel in mask; optionally check read bits.
    task automatic send_bits(input logic [7:0] mask, input logic [7:0] b, input int nbits,
                             input bit chk, input logic [7:0] rd);
        for (int i = 7; i > 7 - nbits; i--) begin
            sins = (sins & ~mask) | (b[i] ? mask : 8'h00);
            repeat (H) @(posedge clk);
            if (chk) begin
                #1;
                check("sout_bit", sout, rd[i]);
                check("sout_enable_read", sout_enable, 1'b1);
                last_rd = {last_rd[6:0], sout};
            end
            sclks = sclks | mask;
            repeat (H) @(posedge clk);
            sclks = sclks & ~mask;
        end
    endtask

    task automatic send_byte(input logic [7:0] mask, input logic [7:0] b);
        send_bits(mask, b, 8, 1'b0, 8'h00);
    endtask

    task automatic send_key(input logic [7:0] mask);
        logic [63:0] key;
        key = 64'h929d9a9b2935a265;
        for (int i = 0; i < 8; i++) send_byte(mask, key[63 - 8*i -: 8]);
    endtask

    // Model: derive the APB accesses and read-back bytes of a burst from its header.
    task automatic run_txn(input logic [7:0] mask, input logic [7:0] idx, input int n,
                           input logic [15:0] addr, input logic [7:0] cmd,
                           input logic [3:0][7:0] wdat, input bit expect_ok);
        logic [7:0] rd_exp [$];
        apb_rec_t r;
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = addr + (cmd[1] ? 16'(i) : 16'h0000);
            if (expect_ok) begin
                if (cmd[0]) begin
                    r = '{a, 1'b1, wdat[i]};
                    model_mem[a] = wdat[i];
                end else begin
                    r = '{a, 1'b0, 8'h00};
                    rd_exp.push_back(model_mem[a]);
                end
                exp_q.push_back(r);
            end
        end
        send_byte(mask, idx);
        send_byte(mask, 8'(n));
        send_byte(mask, addr[7:0]);
        send_byte(mask, addr[15:8]);
        send_byte(mask, cmd);
        if (expect_ok) begin
            #1;
            check("sout_index", sout_index, idx);
        end
        for (int i = 0; i < n; i++) begin
            if (cmd[0]) send_bits(mask, wdat[i], 8, 1'b0, 8'h00);
            else        send_bits(mask, 8'h00, 8, expect_ok, expect_ok ? rd_exp[i] : 8'h00);
        end
        repeat (20) @(posedge clk);
        #1;
        check("apb_all_issued", 32'(exp_q.size()), 32'd0);
        check("sout_enable_after", sout_enable, 1'b0);
        $display("[TB] txn mask=%02h idx=%02h n=%0d addr=%04h cmd=%02h expect=%0b", mask, idx, n, addr, cmd, expect_ok);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]       = 8'(a) ^ 8'(a >> 8) ^ 8'h5c;
            model_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5c;
        end
        mem[16'h0034]       = 8'hc3;
        model_mem[16'h0034] = 8'hc3;
        last_rd = 8'h00;
        rst = 1'b0; sclks = '0; sins = '0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 16'h0000);
        check("rst_pwdata", PWDATA, 8'h00);
        check("rst_sout", sout, 1'b0);
        check("rst_sout_enable", sout_enable, 1'b0);
        check("rst_sout_index", sout_index, 8'h00);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Single-byte read through every channel.
        for (int ch = 0; ch < SC; ch++) begin
            send_key(8'(1 << ch));
            run_txn(8'(1 << ch), 8'h5a, 1, 16'h0034, 8'h00, '0, 1'b1);
            check("read_byte_c3", last_rd, 8'hc3);
        end

        // Auto-increment writes crossing a byte boundary, then full 16-bit wrap.
        send_key(8'h01);
        run_txn(8'h01, 8'h11, 4, 16'h00fe, 8'h03, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        check("mem_00fe", mem[16'h00fe], 8'h11);
        check("mem_00ff", mem[16'h00ff], 8'h22);
        check("mem_0100", mem[16'h0100], 8'h33);
        check("mem_0101", mem[16'h0101], 8'h44);
        send_key(8'h02);
        run_txn(8'h02, 8'h12, 3, 16'hfffe, 8'h03, {8'h00, 8'ha3, 8'ha2, 8'ha1}, 1'b1);
        check("mem_ffff", mem[16'hffff], 8'ha2);
        check("mem_0000", mem[16'h0000], 8'ha3);

        // Auto-increment read burst, then non-incrementing read with upper command bits set.
        send_key(8'h40);
        run_txn(8'h40, 8'h13, 2, 16'h00fe, 8'h02, '0, 1'b1);
        check("read_incr_last", last_rd, 8'h22);
        send_key(8'h80);
        run_txn(8'h80, 8'h14, 3, 16'h0100, 8'hf8, '0, 1'b1);
        check("read_hold_last", last_rd, 8'h33);

        // Zero-length burst performs no access.
        send_key(8'h01);
        run_txn(8'h01, 8'h15, 0, 16'h0200, 8'h01, '0, 1'b1);

        // Simultaneous key on channels 2 and 5: channel 2 owns the burst.
        send_key(8'h24);
        send_key(8'h20);
        run_txn(8'h20, 8'h77, 1, 16'h0010, 8'h01, {8'h00, 8'h00, 8'h00, 8'h99}, 1'b0);
        run_txn(8'h04, 8'h33, 1, 16'h0034, 8'h00, '0, 1'b1);
        check("lock_low_read", last_rd, 8'hc3);

        // Repeated first key byte restarts the match at stage 1.
        send_byte(8'h08, 8'h92);
        send_key(8'h08);
        run_txn(8'h08, 8'h21, 1, 16'h0034, 8'h00, '0, 1'b1);

        // Stalled header times out; the next header needs a fresh key.
        send_key(8'h02);
        send_byte(8'h02, 8'h99);
        repeat (TO + 10) @(posedge clk);
        #1;
        check("timeout_sout_enable", sout_enable, 1'b0);
        run_txn(8'h02, 8'h66, 1, 16'h0040, 8'h01, {8'h00, 8'h00, 8'h00, 8'h5e}, 1'b0);
        check("timeout_no_write", mem[16'h0040], model_mem[16'h0040]);
        send_key(8'h02);
        run_txn(8'h02, 8'h67, 1, 16'h0040, 8'h01, {8'h00, 8'h00, 8'h00, 8'h5e}, 1'b1);
        check("mem_0040", mem[16'h0040], 8'h5e);

        // Reset in the middle of the second byte of a read burst.
        send_key(8'h10);
        r_push_reads();
        send_byte(8'h10, 8'h44);
        send_byte(8'h10, 8'h03);
        send_byte(8'h10, 8'h34);
        send_byte(8'h10, 8'h00);
        send_byte(8'h10, 8'h00);
        send_bits(8'h10, 8'h00, 8, 1'b1, 8'hc3);
        send_bits(8'h10, 8'h00, 3, 1'b1, 8'hc3);
        check("rst_mid_sout_enable_before", sout_enable, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mid_psel", PSEL, 1'b0);
        check("rst_mid_penable", PENABLE, 1'b0);
        check("rst_mid_sout_enable", sout_enable, 1'b0);
        check("rst_mid_sout", sout, 1'b0);
        check("rst_mid_reads_issued", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        run_txn(8'h10, 8'h45, 1, 16'h0050, 8'h01, {8'h00, 8'h00, 8'h00, 8'h7e}, 1'b0);
        send_key(8'h10);
        run_txn(8'h10, 8'h46, 1, 16'h0034, 8'h00, '0, 1'b1);
        check("after_rst_read", last_rd, 8'hc3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Two reads at 0x0034 precede a reset landing inside the second data byte.
    task automatic r_push_reads();
        apb_rec_t r;
        r = '{16'h0034, 1'b0, 8'h00};
        exp_q.push_back(r);
        exp_q.push_back(r);
    endtask
endmodule

// File: doc/control_burst_manager.md
CONTROL_BURST_MANAGER -- requirements
Module: control_burst_manager

Interface
REQ-001 SHALL have parameter SPI_COUNT, default 8, number of SPI slave channels (1..32).
REQ-002 SHALL have parameter INDEX_WIDTH, default 8, width of sout_index.
REQ-003 SHALL have parameter ADDR_BYTES, default 2, APB address bytes sent LSB first (1..4).
REQ-004 SHALL have parameter TIMEOUT, default 4096, idle clk cycles without sclk edge before framing resets.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port sclks  input  SPI_COUNT  per-channel SPI clock, mode 0.
REQ-008 SHALL have port sins  input  SPI_COUNT  per-channel SPI data in, MSB first.
REQ-009 SHALL have port sout  output  1  SPI data out of locked channel.
REQ-010 SHALL have port sout_index  output  INDEX_WIDTH  pin index byte from header.
REQ-011 SHALL have port sout_enable  output  1  high while sout is valid for read data.
REQ-012 SHALL have APB2 master ports PADDR (ADDR_BYTES*8, out), PSEL, PENABLE, PWRITE (1, out), PWDATA (8, out), PRDATA (8, in).

Function
REQ-013 SHALL synchronise every sclks/sins bit with two flops and detect sclk rising/falling edges in clk domain; sclk high/low times >= 4 clk.
REQ-014 SHALL sample sin on sclk rise, shift sout on sclk fall; 8 bits form one byte.
REQ-015 SHALL run a per-channel key matcher for bytes 92 9d 9a 9b 29 35 a2 65; mismatch restarts match (at stage 1 if byte is 0x92).
REQ-016 SHALL lock the first channel completing the key; simultaneous completion -> lowest index wins; other channels ignored until unlock.
REQ-017 SHALL, for the locked channel, step states HDR_INDEX -> HDR_COUNT -> HDR_ADDR (ADDR_BYTES bytes) -> HDR_CMD -> DATA -> IDLE.
REQ-018 SHALL latch sout_index from HDR_INDEX byte; count byte N = data bytes (N=0 -> IDLE after HDR_CMD, no APB access).
REQ-019 SHALL decode command bit0 = write, bit1 = address auto-increment; other bits ignored.
REQ-020 SHALL, for reads, start APB read on HDR_CMD byte completion and on each data-byte completion while bytes remain; result loaded into the shift register before the next byte's first sclk fall.
REQ-021 SHALL, for writes, start one APB write per received data byte with PWDATA = that byte.
REQ-022 SHALL perform APB2 as SETUP (PSEL=1, PENABLE=0) then ACCESS (PSEL=1, PENABLE=1) for one cycle each, PRDATA captured in ACCESS; PADDR/PWRITE/PWDATA stable across both.
REQ-023 SHALL increment address after each access when bit1 set, wrapping modulo 2^(ADDR_BYTES*8); otherwise hold.
REQ-024 SHALL assert sout_enable from HDR_CMD completion (read) until the last data byte's final bit; 0 for writes.
REQ-025 SHALL return to IDLE and unlock after N data bytes, or after TIMEOUT idle cycles in any non-IDLE state; in-flight APB access completes first.
REQ-026 SHALL drive sout = 0 when sout_enable is low.

Reset
REQ-027 SHALL, while rst is low, force PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, sout=0, sout_enable=0, sout_index=0, all matchers to stage 0, no lock.
REQ-028 SHALL on rst deassertion mid-transfer require a full new key before any header is accepted.

Verification
REQ-029 Key on each channel 0..7, index 0x5a, N=1, addr 0x0034, cmd 0x00, mem[0x34]=0xc3 -> one APB read at 0x0034, read byte 0xc3, sout_index=0x5a.
REQ-030 Key, N=4, addr 0x00fe, cmd 0x03, data 11 22 33 44 -> writes at 0x00fe, 0x00ff, 0x0100, 0x0101; ADDR_BYTES=1 build wraps to 0x00, 0x01.
REQ-031 Key on channels 2 and 5 finishing same clk -> channel 2 locked; channel 5 traffic produces no APB access.
REQ-032 Key bytes 92 92 9d 9a 9b 29 35 a2 65 -> key accepted (restart at stage 1).
REQ-033 Key, index, then sclk stops for TIMEOUT+10 clk -> IDLE, unlocked, sout_enable=0; next header without key ignored.
REQ-034 rst low during burst read byte 2 -> PSEL=0, sout_enable=0 immediately; after release full sequence works.
